// File: rtl/pcie_tx_mwr_packetizer.sv
// pcie_tx_mwr_packetizer: builds 4DW-header MWr TLPs onto a 256-bit AXI-stream TX interface
module pcie_tx_mwr_packetizer #(
  parameter int DATA_W = 256,
  parameter int KEEP_W = 32
) (
  input  logic              user_clk,
  input  logic              user_reset,
  input  logic [15:0]       cfg_requester_id,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [63:0]       req_addr,
  input  logic [9:0]        req_len_dw,
  input  logic [7:0]        req_tag,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] s_axis_tx_tdata,
  output logic [KEEP_W-1:0] s_axis_tx_tkeep,
  output logic              s_axis_tx_tlast,
  output logic              s_axis_tx_tvalid,
  input  logic              s_axis_tx_tready,
  output logic [3:0]        s_axis_tx_tuser
);
  typedef enum logic [1:0] {IDLE, HDR, BODY, TAIL} state_t;
  state_t state;
  logic [63:2] addr_q;
  logic [9:0] len_q;
  logic [7:0] tag_q;
  logic [15:0] rid_q;
  logic [10:0] dw_left, dw_next;
  logic [127:0] hold, hdr;
  logic [DATA_W-1:0] raw, beat;
  logic [KEEP_W-1:0] keep;
  logic [3:0] lanes;
  logic out_free, busy, ld;
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[1:0];
  assign s_axis_tx_tuser = 4'b0000;
  // handshake decode, header assembly and the lane-masked next beat
  always_comb begin
    out_free = !s_axis_tx_tvalid || s_axis_tx_tready;
    busy = state == HDR || state == BODY;
    req_ready = state == IDLE && !user_reset;
    wr_ready = busy && out_free;
    ld = out_free && (busy ? wr_valid : state == TAIL);
    hdr = {addr_q[31:2], 2'b00, addr_q[63:32], rid_q, tag_q, (len_q == 10'd1) ? 4'h0 : 4'hF, 4'hF,
           3'b011, 19'd0, len_q};
    raw = {wr_data[127:0], state == HDR ? hdr : hold};
    lanes = state == HDR ? (dw_left >= 11'd4 ? 4'd8 : dw_left[3:0] + 4'd4) :
            state == BODY ? (dw_left >= 11'd8 ? 4'd8 : dw_left[3:0]) : dw_left[3:0];
    dw_next = state == HDR ? (dw_left >= 11'd4 ? dw_left - 11'd4 : 11'd0) :
              state == BODY ? (dw_left >= 11'd8 ? dw_left - 11'd8 : 11'd0) : 11'd0;
    beat = '0;
    keep = '0;
    for (int i = 0; i < 8; i++) begin
      beat[32*i +: 32] = (4'(i) < lanes) ? raw[32*i +: 32] : 32'd0;
      keep[4*i +: 4] = (4'(i) < lanes) ? 4'hF : 4'h0;
    end
  end
  // request latch, FSM and output register stage
  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      state <= IDLE;
      addr_q <= '0;
      len_q <= '0;
      tag_q <= '0;
      rid_q <= '0;
      dw_left <= '0;
      hold <= '0;
      s_axis_tx_tdata <= '0;
      s_axis_tx_tkeep <= '0;
      s_axis_tx_tlast <= 1'b0;
      s_axis_tx_tvalid <= 1'b0;
    end else begin
      if (ld) begin
        s_axis_tx_tdata <= beat;
        s_axis_tx_tkeep <= keep;
        s_axis_tx_tlast <= dw_next == 11'd0;
        s_axis_tx_tvalid <= 1'b1;
        hold <= wr_data[255:128];
        dw_left <= dw_next;
        state <= (dw_next == 11'd0) ? IDLE : (dw_next <= 11'd4) ? TAIL : BODY;
      end else if (s_axis_tx_tready) begin
        s_axis_tx_tvalid <= 1'b0;
      end
      if (state == IDLE && req_valid) begin
        addr_q <= req_addr[63:2];
        len_q <= req_len_dw;
        tag_q <= req_tag;
        rid_q <= cfg_requester_id;
        dw_left <= {req_len_dw == 10'd0, req_len_dw};
        state <= HDR;
      end
    end
  end
endmodule

// File: tb/tb_pcie_tx_mwr_packetizer.sv
// tb_pcie_tx_mwr_packetizer: scoreboard bench for the MWr TLP packetizer
module tb_pcie_tx_mwr_packetizer;
  typedef struct {
    logic [255:0] d;
    logic [31:0]  k;
    logic         l;
  } beat_t;
  logic user_clk = 0, user_reset;
  logic [15:0] cfg_requester_id;
  logic req_valid, req_ready;
  logic [63:0] req_addr;
  logic [9:0] req_len_dw;
  logic [7:0] req_tag;
  logic [255:0] wr_data;
  logic wr_valid, wr_ready;
  logic [255:0] s_axis_tx_tdata;
  logic [31:0] s_axis_tx_tkeep;
  logic s_axis_tx_tlast, s_axis_tx_tvalid, s_axis_tx_tready;
  logic [3:0] s_axis_tx_tuser;
  beat_t exp_q[$];
  logic [31:0] pay [1024];
  int total = 0, bad = 0, wr_hs = 0, nbeat = 0;
  bit bp = 0, sb_off = 0, prev_stall = 0;
  logic [255:0] pd;
  logic [31:0] pk;
  logic pl;
  pcie_tx_mwr_packetizer dut (
    .user_clk(user_clk), .user_reset(user_reset), .cfg_requester_id(cfg_requester_id),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len_dw(req_len_dw),
    .req_tag(req_tag), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .s_axis_tx_tdata(s_axis_tx_tdata), .s_axis_tx_tkeep(s_axis_tx_tkeep),
    .s_axis_tx_tlast(s_axis_tx_tlast), .s_axis_tx_tvalid(s_axis_tx_tvalid),
    .s_axis_tx_tready(s_axis_tx_tready), .s_axis_tx_tuser(s_axis_tx_tuser)
  );
  always #5 user_clk = ~user_clk;
  // sink: always ready, or random backpressure when bp is set
  initial begin
    s_axis_tx_tready = 1'b1;
    forever begin
      @(posedge user_clk);
      #1;
      s_axis_tx_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end
  // monitor: hold-stability while stalled, scoreboard pop on every accepted beat
  always @(negedge user_clk) begin
    beat_t e;
    if (user_reset) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        total++;
        if (!(s_axis_tx_tvalid && s_axis_tx_tdata === pd && s_axis_tx_tkeep === pk && s_axis_tx_tlast === pl)) begin
          bad++;
          $display("FAIL stall_hold: got v=%b k=%h l=%b d=%h want v=1 k=%h l=%b d=%h",
                   s_axis_tx_tvalid, s_axis_tx_tkeep, s_axis_tx_tlast, s_axis_tx_tdata, pk, pl, pd);
        end
      end
      if (s_axis_tx_tvalid && s_axis_tx_tready && !sb_off) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_beat: got k=%h l=%b want no beat", s_axis_tx_tkeep, s_axis_tx_tlast);
        end else begin
          e = exp_q.pop_front();
          if (s_axis_tx_tdata !== e.d || s_axis_tx_tkeep !== e.k || s_axis_tx_tlast !== e.l || s_axis_tx_tuser !== 4'd0) begin
            bad++;
            $display("FAIL beat%0d: got d=%h k=%h l=%b u=%h want d=%h k=%h l=%b u=0",
                     nbeat, s_axis_tx_tdata, s_axis_tx_tkeep, s_axis_tx_tlast, s_axis_tx_tuser, e.d, e.k, e.l);
          end
        end
        nbeat++;
      end
      prev_stall = s_axis_tx_tvalid && !s_axis_tx_tready;
      pd = s_axis_tx_tdata;
      pk = s_axis_tx_tkeep;
      pl = s_axis_tx_tlast;
      if (wr_valid && wr_ready) wr_hs++;
    end
  end
  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  function automatic logic [31:0] pdw(input int idx, input int n);
    return idx < n ? pay[idx] : (32'hDEAD_0000 | 32'(idx));
  endfunction
  task automatic run_mwr(input logic [9:0] len, input logic [63:0] addr, input logic [7:0] tag,
                         input logic [15:0] rid, input bit bpm, input bit gaps);
    int n, nb, nin, hs0, t, p;
    logic [31:0] hw [4];
    beat_t e;
    n = (len == 10'd0) ? 1024 : int'(len);
    nb = (n + 11) / 8;
    nin = (n + 7) / 8;
    for (int j = 0; j < n; j++) pay[j] = {tag, 8'hC3, 16'(j)};
    hw[0] = 32'h6000_0000 | {22'd0, len};
    hw[1] = {rid, tag, (n > 1) ? 4'hF : 4'h0, 4'hF};
    hw[2] = addr[63:32];
    hw[3] = {addr[31:2], 2'b00};
    for (int b = 0; b < nb; b++) begin
      e.d = '0;
      e.k = '0;
      for (int ln = 0; ln < 8; ln++) begin
        p = 8 * b + ln;
        if (p < n + 4) begin
          e.k[4*ln +: 4] = 4'hF;
          e.d[32*ln +: 32] = (p < 4) ? hw[p] : pay[p-4];
        end
      end
      e.l = (b == nb - 1);
      exp_q.push_back(e);
    end
    bp = bpm;
    hs0 = wr_hs;
    fork
      begin
        int tr;
        tr = 0;
        req_valid = 1;
        req_addr = addr;
        req_len_dw = len;
        req_tag = tag;
        cfg_requester_id = rid;
        @(negedge user_clk);
        while (!req_ready && tr < 200) begin
          @(negedge user_clk);
          tr++;
        end
        if (!req_ready) begin
          bad++;
          $display("FAIL req_accept: got req_ready=0 want 1 within 200 cycles");
        end
        @(posedge user_clk);
        #1;
        req_valid = 0;
      end
      begin
        int td;
        for (int k = 0; k < nin; k++) begin
          if (gaps) begin
            wr_valid = 0;
            repeat ($urandom_range(0, 2)) begin
              @(posedge user_clk);
              #1;
            end
          end
          for (int i = 0; i < 8; i++) wr_data[32*i +: 32] = pdw(8 * k + i, n);
          wr_valid = 1;
          td = 0;
          @(negedge user_clk);
          while (!wr_ready && td < 300) begin
            @(negedge user_clk);
            td++;
          end
          if (!wr_ready) begin
            bad++;
            $display("FAIL wr_accept: got wr_ready=0 want 1 at input beat %0d", k);
            break;
          end
          @(posedge user_clk);
          #1;
        end
      end
    join
    wr_data = {8{32'hBADD_A7A0}};
    wr_valid = 1;
    t = 0;
    while (exp_q.size() != 0 && t < 4000) begin
      @(negedge user_clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL tlp_done: got %0d beats outstanding want 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge user_clk);
    #1;
    repeat (2) @(posedge user_clk);
    #1;
    wr_valid = 0;
    bp = 0;
    chk("wr_handshakes", 256'(wr_hs - hs0), 256'(nin));
    @(negedge user_clk);
    chk("req_ready_after", 256'(req_ready), 256'd1);
    @(posedge user_clk);
    #1;
  endtask
  initial begin
    int hs0, t;
    user_reset = 1;
    req_valid = 0;
    req_addr = '0;
    req_len_dw = '0;
    req_tag = '0;
    cfg_requester_id = '0;
    wr_valid = 0;
    wr_data = '0;
    repeat (3) @(posedge user_clk);
    #1;
    chk("rst_tvalid", 256'(s_axis_tx_tvalid), 256'd0);
    chk("rst_req_ready", 256'(req_ready), 256'd0);
    chk("rst_wr_ready", 256'(wr_ready), 256'd0);
    chk("rst_tkeep", 256'(s_axis_tx_tkeep), 256'd0);
    user_reset = 0;
    @(negedge user_clk);
    chk("idle_req_ready", 256'(req_ready), 256'd1);
    @(posedge user_clk);
    #1;
    run_mwr(10'd1, 64'h0000_0001_2345_6788, 8'h5A, 16'h0100, 0, 0);
    run_mwr(10'd4, 64'h0000_0000_8000_0010, 8'h01, 16'h0100, 0, 0);
    run_mwr(10'd5, 64'hFFFF_0000_0000_0100, 8'h02, 16'h0108, 0, 0);
    run_mwr(10'd16, 64'h0000_0002_0000_1000, 8'h03, 16'h0100, 0, 0);
    run_mwr(10'd0, 64'h0000_0003_0000_0000, 8'h04, 16'h0100, 0, 0);
    run_mwr(10'd20, 64'h0000_0000_1234_567B, 8'h05, 16'h0A01, 1, 1);
    run_mwr(10'd20, 64'h0000_0007_0000_0040, 8'h06, 16'h0A01, 1, 1);
    run_mwr(10'd8, 64'h0000_0000_0000_2000, 8'h07, 16'h0100, 1, 0);
    sb_off = 1;
    req_valid = 1;
    req_len_dw = 10'd64;
    req_addr = 64'h0000_0010_0000_0000;
    req_tag = 8'h77;
    cfg_requester_id = 16'h0200;
    wr_valid = 1;
    wr_data = {8{32'h1111_2222}};
    @(posedge user_clk);
    #1;
    req_valid = 0;
    hs0 = wr_hs;
    t = 0;
    while (wr_hs < hs0 + 3 && t < 100) begin
      @(negedge user_clk);
      t++;
    end
    chk("mid_body_hs", 256'(wr_hs - hs0), 256'd3);
    @(posedge user_clk);
    #3;
    user_reset = 1;
    #1;
    chk("mid_rst_tvalid", 256'(s_axis_tx_tvalid), 256'd0);
    chk("mid_rst_tdata", s_axis_tx_tdata, 256'd0);
    chk("mid_rst_tkeep", 256'(s_axis_tx_tkeep), 256'd0);
    chk("mid_rst_tlast", 256'(s_axis_tx_tlast), 256'd0);
    chk("mid_rst_tuser", 256'(s_axis_tx_tuser), 256'd0);
    chk("mid_rst_req_ready", 256'(req_ready), 256'd0);
    chk("mid_rst_wr_ready", 256'(wr_ready), 256'd0);
    wr_valid = 0;
    exp_q.delete();
    repeat (2) @(posedge user_clk);
    #1;
    user_reset = 0;
    sb_off = 0;
    @(negedge user_clk);
    chk("post_rst_req_ready", 256'(req_ready), 256'd1);
    @(posedge user_clk);
    #1;
    run_mwr(10'd2, 64'h0000_0000_0000_0400, 8'h99, 16'h0300, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pcie_tx_mwr_packetizer.md
Name: pcie_tx_mwr_packetizer

Overview:
- Transmit-side TLP builder that drives the endpoint's s_axis_tx_* stream.
- Accepts memory-write requests (address, length, tag) plus a 256-bit payload stream.
- Emits a 4DW-header MWr TLP as 256-bit AXI-stream beats with tkeep/tlast.
- Sits between user DMA logic and the endpoint's TX interface, in the user_clk domain.

Parameters:
- DATA_W, 256, stream data width in bits (8 DW per beat).
- KEEP_W, 32, byte-enable width; always DATA_W/8.

Ports:
- user_clk  in  1  clock; all logic is on the rising edge.
- user_reset  in  1  reset; asynchronous, active-high.
- cfg_requester_id  in  16  bus/dev/func value placed in header DW1.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_addr  in  64  DW-aligned byte address; bits [1:0] are ignored.
- req_len_dw  in  10  payload length in DW; 0 encodes 1024.
- req_tag  in  8  tag placed in header DW1.
- wr_data  in  256  payload; DW i occupies bits [32i+31:32i].
- wr_valid  in  1  payload beat valid.
- wr_ready  out  1  payload beat consumed when wr_valid && wr_ready.
- s_axis_tx_tdata  out  256  TLP beat.
- s_axis_tx_tkeep  out  32  byte qualifiers.
- s_axis_tx_tlast  out  1  last beat of the TLP.
- s_axis_tx_tvalid  out  1  beat valid.
- s_axis_tx_tready  in  1  sink accepts the beat.
- s_axis_tx_tuser  out  4  always 4'b0000.

Behaviour:
- Reset: every output is 0, except req_ready, which goes to 1 once reset deasserts with the FSM in IDLE. State returns to IDLE, counters clear, and holding register clears. Reset mid-TLP abandons the packet without sending tlast.
- Output register stage: out_free = !tvalid || tready. A new beat loads only when out_free. While tvalid && !tready, tdata, tkeep and tlast hold stable.
- Header:
  - DW0 = {3'b011, 5'b00000, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b0, 2'b00, 2'b00, len[9:0]}.
  - DW1 = {requester_id, tag, lastBE, 4'hF}, where lastBE = 4'hF if N>1, else 4'h0.
  - DW2 = addr[63:32].
  - DW3 = {addr[31:2], 2'b00}.
  - N = payload DW, 1..1024.
- Beat layout:
  - Beat0: lanes 0-3 carry header DW0-3; lanes 4-7 carry payload DW0-3 from input beat 0.
  - Input beat 0 DW4-7 go into a 4-DW holding register.
  - Beat k≥1: lanes 0-3 carry the holding register; lanes 4-7 carry DW0-3 of input beat k. The new beat's DW4-7 then refill the holding register.
- Counts:
  - Output beats = ceil((N+4)/8).
  - Input beats = ceil(N/8).
  - Unused DW in the final input beat are ignored.
- FSM:
  - IDLE: req_ready=1. On accept, latch fields, set dw_left = N (11 bits), go to HDR.
  - HDR: wr_ready = out_free. On wr_valid && out_free, load beat0 and subtract min(N,4) from dw_left.
    - If dw_left becomes 0, go to IDLE (beat0 carries tlast).
    - If dw_left ≤ 4 (the rest is already held), go to TAIL.
    - Otherwise go to BODY.
  - BODY: wr_ready = out_free. On handshake, load beat k and subtract min(dw_left,8).
    - Go to IDLE if dw_left becomes 0; go to TAIL if dw_left ≤ 4.
  - TAIL: wr_ready=0. When out_free, load the held DW only and go to IDLE.
- tkeep and tlast:
  - tlast=1 on the beat that reduces dw_left to 0.
  - tkeep on that beat = ones for ((N+4) mod 8) DW, or all ones when the mod is 0; unused lanes' tdata = 0.
  - tkeep on all non-last beats = 32'hFFFFFFFF.
- Latency: request accepted at edge T → HDR at T+1 → tvalid at T+2 if wr_valid at T+1.
- Back-to-back: req_ready returns the cycle after the final beat loads. No idle beat is required between TLPs on the stream beyond this.
- Gaps: a wr_valid gap in HDR/BODY stalls without emitting a bubble beat; tvalid drops once the pending beat is taken.
- req_ready=0 outside IDLE; wr_ready=0 in IDLE and TAIL. Data arriving early is never consumed.

Test Plan:
- N=1, addr=0x0000_0001_2345_6788, tag=0x5A, rid=0x0100:
  - Exactly 1 beat; tkeep=0x000FFFFF; tlast=1.
  - DW0=0x60000001, DW1=0x01005A0F, DW2=0x00000001, DW3=0x23456788, DW4 = wr_data DW0.
- N=4: 1 beat, tkeep=0xFFFFFFFF, tlast=1, one input beat consumed. N=5: 2 beats, second has tkeep=0x0000000F and goes through TAIL with no extra wr_ready.
- N=16, continuous data: 3 output beats (tkeep F..F, F..F, 0x0000FFFF) from 2 input beats; payload order is preserved exactly.
- N=0 (1024 DW): 129 beats; DW0 length field = 0; final tkeep=0x0000FFFF; exactly 128 wr handshakes.
- Random tready backpressure and wr_valid gaps on N=20: tdata/tkeep/tlast stay stable while stalled; no lost or duplicated DW; tuser stays 0.
- Assert user_reset during BODY of N=64: all outputs 0 immediately; after release, a fresh N=2 request produces a correct single-beat TLP.
